// File: rtl/ethernet_header_capture.sv
// Ethernet header capture: finds preamble + SFD in a byte stream and captures the
// following HDR_BYTES bytes, tolerating short i_valid gaps mid-header.
module ethernet_header_capture #(
    parameter int unsigned HDR_BYTES = 42,
    parameter int unsigned PRE_LEN   = 7,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned MAX_GAP   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_valid,
    input  logic [7:0]             i_msg_word,
    output logic                   o_sfd_det,
    output logic [8*HDR_BYTES-1:0] o_header,
    output logic                   o_hdr_valid,
    output logic                   o_hdr_err,
    output logic                   o_busy
);

    localparam int unsigned PreW = $clog2(PRE_LEN + 1);
    localparam int unsigned HdrW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam int unsigned GapW = $clog2(MAX_GAP + 1);

    localparam logic [7:0] PreByte = 8'h55;
    localparam logic [7:0] SfdByte = 8'hD5;

    localparam logic [PreW-1:0] PreMax  = PreW'(PRE_LEN);
    localparam logic [HdrW-1:0] HdrLast = HdrW'(HDR_BYTES - 1);
    localparam logic [GapW-1:0] GapMax  = GapW'(MAX_GAP);

    typedef enum logic [0:0] {
        StIdle,
        StCapture
    } state_e;

    state_e                 state_q, state_d;
    logic [PreW-1:0]        pre_cnt_q, pre_cnt_d;
    logic [HdrW-1:0]        hdr_cnt_q, hdr_cnt_d;
    logic [GapW-1:0]        gap_q, gap_d;
    logic [8*HDR_BYTES-1:0] header_q, header_d;
    logic                   sfd_det_q, sfd_det_d;
    logic                   hdr_valid_q, hdr_valid_d;
    logic                   hdr_err_q, hdr_err_d;
    logic                   busy_q;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        hdr_cnt_d   = hdr_cnt_q;
        gap_d       = gap_q;
        header_d    = header_q;
        sfd_det_d   = 1'b0;
        hdr_valid_d = 1'b0;
        hdr_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    if (i_msg_word == SfdByte && pre_cnt_q >= PreMax) begin
                        state_d   = StCapture;
                        hdr_cnt_d = '0;
                        header_d  = '0;
                        pre_cnt_d = '0;
                        gap_d     = '0;
                        sfd_det_d = 1'b1;
                    end else if (i_msg_word == PreByte) begin
                        if (pre_cnt_q != PreMax) begin
                            pre_cnt_d = pre_cnt_q + PreW'(1);
                        end
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
            end

            StCapture: begin
                if (i_valid) begin
                    gap_d = '0;
                    if (MSB_FIRST) begin
                        header_d      = header_q << 8;
                        header_d[7:0] = i_msg_word;
                    end else begin
                        header_d[8*hdr_cnt_q +: 8] = i_msg_word;
                    end
                    if (hdr_cnt_q == HdrLast) begin
                        state_d     = StIdle;
                        hdr_cnt_d   = '0;
                        hdr_valid_d = 1'b1;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + HdrW'(1);
                    end
                end else if (gap_q == GapMax) begin
                    // One idle beat beyond the tolerated gap: drop the partial header.
                    state_d   = StIdle;
                    header_d  = '0;
                    hdr_cnt_d = '0;
                    gap_d     = '0;
                    hdr_err_d = 1'b1;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            pre_cnt_q   <= '0;
            hdr_cnt_q   <= '0;
            gap_q       <= '0;
            header_q    <= '0;
            sfd_det_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            hdr_cnt_q   <= hdr_cnt_d;
            gap_q       <= gap_d;
            header_q    <= header_d;
            sfd_det_q   <= sfd_det_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_err_q   <= hdr_err_d;
            busy_q      <= (state_d == StCapture);
        end
    end

    assign o_sfd_det   = sfd_det_q;
    assign o_header    = header_q;
    assign o_hdr_valid = hdr_valid_q;
    assign o_hdr_err   = hdr_err_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_ethernet_header_capture.sv
// Bench for ethernet_header_capture: two instances (default and 4-byte LSB-first) share one
// stimulus stream; a byte-list reference model feeds a per-cycle scoreboard.
module tb_ethernet_header_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       vld;
    logic [7:0] word;

    logic         sfd_a, hv_a, err_a, busy_a;
    logic [335:0] hdr_a;
    logic         sfd_b, hv_b, err_b, busy_b;
    logic [31:0]  hdr_b;

    ethernet_header_capture u_dut_a (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_valid     (vld),
        .i_msg_word  (word),
        .o_sfd_det   (sfd_a),
        .o_header    (hdr_a),
        .o_hdr_valid (hv_a),
        .o_hdr_err   (err_a),
        .o_busy      (busy_a)
    );

    ethernet_header_capture #(
        .HDR_BYTES (4),
        .PRE_LEN   (7),
        .MSB_FIRST (1'b0),
        .MAX_GAP   (4)
    ) u_dut_b (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_valid     (vld),
        .i_msg_word  (word),
        .o_sfd_det   (sfd_b),
        .o_header    (hdr_b),
        .o_hdr_valid (hv_b),
        .o_hdr_err   (err_b),
        .o_busy      (busy_b)
    );

    typedef struct {
        int           edge_n;
        logic [1:0]   sfd;
        logic [1:0]   hv;
        logic [1:0]   err;
        logic [1:0]   busy;
        logic [511:0] hdr_a;
        logic [511:0] hdr_b;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a frame is a list of bytes seen since the SFD; the header is that list
    // laid out per byte order.
    int           run[2];
    bit           inf[2];
    int           gap[2];
    int           nb[2];
    logic [7:0]   bytes[2][64];
    logic [511:0] mhdr[2];

    task automatic model_step(input int c, input logic r, input logic v, input logic [7:0] b,
                              output logic sfd, output logic hv, output logic err);
        int hbytes;
        bit msb;
        hbytes = (c == 0) ? 42 : 4;
        msb    = (c == 0);
        sfd = 1'b0;
        hv  = 1'b0;
        err = 1'b0;
        if (!r) begin
            inf[c] = 1'b0; run[c] = 0; gap[c] = 0; nb[c] = 0; mhdr[c] = '0;
        end else if (!inf[c]) begin
            if (v) begin
                if (b == 8'hD5 && run[c] >= 7) begin
                    inf[c] = 1'b1; nb[c] = 0; gap[c] = 0; run[c] = 0; mhdr[c] = '0;
                    sfd = 1'b1;
                end else if (b == 8'h55) begin
                    run[c]++;
                end else begin
                    run[c] = 0;
                end
            end
        end else if (v) begin
            bytes[c][nb[c]] = b;
            nb[c]++;
            gap[c] = 0;
            mhdr[c] = '0;
            for (int i = 0; i < nb[c]; i++) begin
                if (msb) mhdr[c] = (mhdr[c] << 8) | {504'd0, bytes[c][i]};
                else     mhdr[c][8*i +: 8] = bytes[c][i];
            end
            if (nb[c] == hbytes) begin
                inf[c] = 1'b0; nb[c] = 0; hv = 1'b1;
            end
        end else begin
            gap[c]++;
            if (gap[c] > 4) begin
                inf[c] = 1'b0; mhdr[c] = '0; nb[c] = 0; gap[c] = 0; err = 1'b1;
            end
        end
    endtask

    // Drive one beat, record what both instances must show after the coming edge.
    task automatic beat(input logic r, input logic v, input logic [7:0] b);
        exp_t e;
        logic s, h, er;
        rst_n = r;
        vld   = v;
        word  = b;
        e.edge_n = cyc + 1;
        for (int c = 0; c < 2; c++) begin
            model_step(c, r, v, b, s, h, er);
            e.sfd[c]  = s;
            e.hv[c]   = h;
            e.err[c]  = er;
            e.busy[c] = inf[c];
        end
        e.hdr_a = mhdr[0];
        e.hdr_b = mhdr[1];
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    exp_t cur;
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].edge_n == cyc) begin
            cur = sb.pop_front();
            chk("a_sfd_det",   {511'd0, sfd_a},  {511'd0, cur.sfd[0]});
            chk("a_hdr_valid", {511'd0, hv_a},   {511'd0, cur.hv[0]});
            chk("a_hdr_err",   {511'd0, err_a},  {511'd0, cur.err[0]});
            chk("a_busy",      {511'd0, busy_a}, {511'd0, cur.busy[0]});
            chk("a_header",    {176'd0, hdr_a},  cur.hdr_a);
            chk("b_sfd_det",   {511'd0, sfd_b},  {511'd0, cur.sfd[1]});
            chk("b_hdr_valid", {511'd0, hv_b},   {511'd0, cur.hv[1]});
            chk("b_hdr_err",   {511'd0, err_b},  {511'd0, cur.err[1]});
            chk("b_busy",      {511'd0, busy_b}, {511'd0, cur.busy[1]});
            chk("b_header",    {480'd0, hdr_b},  cur.hdr_b);
        end
    end

    task automatic send_frame(input int npre, input int nbytes, input logic [7:0] base,
                              input logic [7:0] step, input int gap_after, input int gap_len);
        logic [7:0] bb;
        repeat (npre) beat(1'b1, 1'b1, 8'h55);
        beat(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < nbytes; i++) begin
            bb = base + 8'(i) * step;
            beat(1'b1, 1'b1, bb);
            if (i + 1 == gap_after) repeat (gap_len) beat(1'b1, 1'b0, 8'(($urandom)));
        end
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 8'h55;
        if (r == 3) return 8'hD5;
        return 8'($urandom);
    endfunction

    initial begin
        for (int c = 0; c < 2; c++) begin
            run[c] = 0; inf[c] = 1'b0; gap[c] = 0; nb[c] = 0; mhdr[c] = '0;
        end
        repeat (3) beat(1'b0, 1'b0, 8'h00);

        // Default frame 0x01..0x2A, then a short preamble that must be ignored.
        send_frame(7, 42, 8'h01, 8'h01, 0, 0);
        beat(1'b1, 1'b1, 8'h00);
        send_frame(6, 42, 8'h01, 8'h01, 0, 0);
        beat(1'b1, 1'b1, 8'h00);

        // LSB-first 4-byte header AA BB CC DD.
        repeat (7) beat(1'b1, 1'b1, 8'h55);
        beat(1'b1, 1'b1, 8'hD5);
        beat(1'b1, 1'b1, 8'hAA);
        beat(1'b1, 1'b1, 8'hBB);
        beat(1'b1, 1'b1, 8'hCC);
        beat(1'b1, 1'b1, 8'hDD);
        for (int i = 0; i < 38; i++) beat(1'b1, 1'b1, 8'(i + 1));

        // Gap of MAX_GAP tolerated, one more aborts.
        send_frame(7, 42, 8'h30, 8'h01, 10, 4);
        send_frame(7, 42, 8'h60, 8'h01, 10, 5);
        beat(1'b1, 1'b1, 8'h00);

        // Reset mid-capture, then a clean frame.
        send_frame(7, 20, 8'h40, 8'h01, 0, 0);
        beat(1'b0, 1'b1, 8'h55);
        send_frame(7, 42, 8'hA0, 8'h03, 0, 0);

        // Back-to-back frames.
        send_frame(7, 42, 8'h11, 8'h00, 0, 0);
        send_frame(7, 42, 8'h22, 8'h00, 0, 0);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    repeat ($urandom_range(5, 9)) beat(1'b1, 1'b1, 8'h55);
                    beat(1'b1, 1'b1, 8'hD5);
                    for (int i = 0; i < int'($urandom_range(1, 45)); i++) begin
                        if ($urandom_range(0, 7) == 0)
                            repeat ($urandom_range(1, 6)) beat(1'b1, 1'b0, pick());
                        beat(1'b1, 1'b1, pick());
                    end
                end
                2: begin
                    repeat ($urandom_range(10, 30))
                        beat(1'b1, ($urandom_range(0, 3) != 0), pick());
                end
                default: begin
                    repeat ($urandom_range(7, 8)) beat(1'b1, 1'b1, 8'h55);
                    beat(1'b1, 1'b1, 8'hD5);
                    repeat ($urandom_range(1, 30)) beat(1'b1, 1'b1, pick());
                    beat(1'b0, $urandom_range(0, 1) == 1, pick());
                end
            endcase
        end

        repeat (4) beat(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 512'(sb.size()), 512'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ethernet_header_capture.md
ETHERNET_HEADER_CAPTURE -- requirements
Module: ethernet_header_capture

Interface
REQ-001 SHALL have parameter HDR_BYTES, default 42: number of header bytes captured after SFD, range 1..64.
REQ-002 SHALL have parameter PRE_LEN, default 7: minimum consecutive 0x55 bytes required before SFD, range 1..15.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = first header byte lands in o_header[8*HDR_BYTES-1 -: 8]; 0 = first byte lands in o_header[7:0].
REQ-004 SHALL have parameter MAX_GAP, default 4: maximum consecutive i_valid-low cycles tolerated mid-header, range 1..255.
REQ-005 SHALL have port i_clk, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port i_reset_n, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port i_valid, input, 1: i_msg_word is sampled only when high.
REQ-008 SHALL have port i_msg_word, input, 8: received byte stream.
REQ-009 SHALL have port o_sfd_det, output, 1: one-cycle pulse on accepted SFD.
REQ-010 SHALL have port o_header, output, 8*HDR_BYTES: captured header.
REQ-011 SHALL have port o_hdr_valid, output, 1: one-cycle pulse when header complete.
REQ-012 SHALL have port o_hdr_err, output, 1: one-cycle pulse on capture abort.
REQ-013 SHALL have port o_busy, output, 1: high while in CAPTURE.

Function
REQ-014 SHALL implement states IDLE and CAPTURE; all outputs registered.
REQ-015 IDLE: on valid beat, byte 0x55 increments pre_cnt (saturating at PRE_LEN); any other byte clears pre_cnt, except as in REQ-016.
REQ-016 IDLE: valid beat with byte 0xD5 and pre_cnt >= PRE_LEN -> CAPTURE, hdr_cnt <= 0, o_header <= 0, pre_cnt <= 0, o_sfd_det high next cycle.
REQ-017 IDLE: 0xD5 with pre_cnt < PRE_LEN -> stay IDLE, pre_cnt <= 0, no pulse.
REQ-018 IDLE: invalid beats hold pre_cnt unchanged.
REQ-019 CAPTURE: each valid beat stores the byte per MSB_FIRST (MSB_FIRST=1: o_header shifts left 8, byte into [7:0]; MSB_FIRST=0: byte written at [8*hdr_cnt +: 8]) and increments hdr_cnt; gap counter cleared.
REQ-020 CAPTURE: header bytes are not pattern-checked; 0x55/0xD5 in header are plain data.
REQ-021 CAPTURE: valid beat with hdr_cnt == HDR_BYTES-1 stores final byte, -> IDLE, o_hdr_valid high the next cycle with o_header already holding the complete header.
REQ-022 Latency: o_hdr_valid asserts exactly 1 cycle after last header byte is sampled; o_sfd_det 1 cycle after SFD is sampled.
REQ-023 o_header SHALL hold its value after o_hdr_valid until the next accepted SFD or abort.
REQ-024 CAPTURE: gap counter increments each i_valid-low cycle; when it would exceed MAX_GAP -> IDLE, o_header <= 0, hdr_cnt <= 0, o_hdr_err high next cycle.
REQ-025 o_busy SHALL be high exactly in the cycles the state register is CAPTURE.
REQ-026 o_sfd_det, o_hdr_valid, o_hdr_err SHALL be mutually exclusive in any cycle.
REQ-027 Counter widths SHALL be sized from parameters ($clog2), no wrap within legal ranges.

Reset
REQ-028 i_reset_n low at a rising edge SHALL force IDLE, pre_cnt=0, hdr_cnt=0, gap=0, o_header=0, all pulses and o_busy 0, overriding any other event.
REQ-029 Reset mid-CAPTURE SHALL discard partial header without o_hdr_err.
REQ-030 First valid beat after release SHALL be processed normally.

Verification
REQ-031 Defaults; 7x0x55, 0xD5, bytes 0x01..0x2A contiguous -> o_sfd_det 1 cycle after 0xD5; o_hdr_valid 1 cycle after 0x2A; o_header[335:328]=0x01, [7:0]=0x2A.
REQ-032 6x0x55, 0xD5, 42 bytes -> no o_sfd_det, no o_hdr_valid, o_header stays 0.
REQ-033 MSB_FIRST=0, HDR_BYTES=4: 7x0x55, 0xD5, 0xAA,0xBB,0xCC,0xDD -> o_header=0xDDCCBBAA with o_hdr_valid.
REQ-034 Valid frame with i_valid low 4 cycles after byte 10 -> completes normally; low 5 cycles -> o_hdr_err pulse, o_header=0, o_busy=0.
REQ-035 i_reset_n low for 1 cycle after 20 header bytes -> all outputs 0, no o_hdr_err; subsequent full frame captured correctly.
REQ-036 Two back-to-back frames with header 0x11.. then 0x22.. -> o_header cleared at second SFD, second o_hdr_valid shows only second header.
